// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: single-step shift/rotate/load/clear
// operations plus a counted burst engine with a busy/done handshake.
module universal_shift_register #(
  parameter  int unsigned WIDTH = 6,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             so_right,
  output logic             so_left,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_LOAD = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_done, w_done_nxt;
  op_t              w_mode;

  assign w_mode = op_t'(mode);

  function automatic logic [WIDTH-1:0] apply_op(
    input op_t              op,
    input logic [WIDTH-1:0] cur,
    input logic             sin,
    input logic [WIDTH-1:0] par
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      OP_SHR:  res = {sin, cur[WIDTH-1:1]};
      OP_SHL:  res = {cur[WIDTH-2:0], sin};
      OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_LOAD: res = par;
      OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLR:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic logic is_burst_op(input op_t op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        // A burst request consumes the edge: q holds while op/count are latched.
        if (start && is_burst_op(w_mode)) begin
          if (count != '0) begin
            w_state_nxt = BUSY;
            w_op_nxt    = w_mode;
            w_rem_nxt   = count;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_q_nxt = apply_op(w_mode, r_q, serial_in, par_in);
        end
      end
      BUSY: begin
        w_q_nxt   = apply_op(r_op, r_q, serial_in, par_in);
        w_rem_nxt = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= OP_HOLD;
      r_rem   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_rem   <= w_rem_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign q        = r_q;
  assign so_right = r_q[0];
  assign so_left  = r_q[WIDTH-1];
  assign busy     = (r_state == BUSY);
  assign done     = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed steps drive a
// reference model whose predictions are queued and checked after each edge.
module tb_universal_shift_register;

  localparam int unsigned W  = 6;
  localparam int unsigned CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic          serial_in;
  logic [W-1:0]  par_in;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          so_right, so_left, busy, done;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .serial_in (serial_in),
    .par_in    (par_in),
    .start     (start),
    .count     (count),
    .q         (q),
    .so_right  (so_right),
    .so_left   (so_left),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_q;
  logic         m_busy, m_done;
  logic [2:0]   m_op;
  int           m_rem;

  function automatic logic [W-1:0] ref_op(input logic [2:0] m, input logic [W-1:0] cur,
                                          input logic s, input logic [W-1:0] p);
    logic [W-1:0] r;
    logic [W-1:0] msb_mask;
    msb_mask = {1'b1, {(W-1){1'b0}}};
    r = cur;
    case (m)
      3'd1: begin r = cur >> 1; r[W-1] = s; end
      3'd2: begin r = cur << 1; r[0] = s; end
      3'd3: r = (cur >> 1) | (cur << (W-1));
      3'd4: r = (cur << 1) | (cur >> (W-1));
      3'd5: r = p;
      3'd6: r = (cur >> 1) | (cur & msb_mask);
      3'd7: r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"},        q,            e.q);
      chk({e.tag, ".so_right"}, W'(so_right), W'(e.q[0]));
      chk({e.tag, ".so_left"},  W'(so_left),  W'(e.q[W-1]));
      chk({e.tag, ".busy"},     W'(busy),     W'(e.busy));
      chk({e.tag, ".done"},     W'(done),     W'(e.done));
    end
  endtask

  task automatic cycle(input string tag, input logic [2:0] m, input logic s,
                       input logic [W-1:0] p, input logic st, input logic [CW-1:0] c);
    exp_t e;
    @(negedge clk);
    mode = m; serial_in = s; par_in = p; start = st; count = c;
    if (m_busy) begin
      m_q = ref_op(m_op, m_q, s, p);
      m_rem--;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (st && (m == 3'd1 || m == 3'd2 || m == 3'd3 || m == 3'd4 || m == 3'd6)) begin
        if (c == '0) m_done = 1'b1;
        else begin
          m_busy = 1'b1;
          m_rem  = int'(c);
          m_op   = m;
        end
      end else begin
        m_q = ref_op(m, m_q, s, p);
      end
    end
    e.tag = tag; e.q = m_q; e.busy = m_busy; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic reset_mid_cycle(input string tag);
    #3;
    reset = 1'b0;
    #1;
    chk({tag, ".q"},        q,            '0);
    chk({tag, ".so_left"},  W'(so_left),  '0);
    chk({tag, ".so_right"}, W'(so_right), '0);
    chk({tag, ".busy"},     W'(busy),     '0);
    chk({tag, ".done"},     W'(done),     '0);
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    mode = 3'd0; start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int busy_cycles;

  initial begin
    reset = 1'b0; mode = '0; serial_in = 1'b0; par_in = '0; start = 1'b0; count = '0;
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_op = '0; m_rem = 0;
    #2;
    chk("reset.q",    q,        '0);
    chk("reset.busy", W'(busy), '0);
    chk("reset.done", W'(done), '0);
    @(negedge clk);
    reset = 1'b1;

    cycle("load_ones", 3'd5, 1'b0, 6'b111111, 1'b0, '0);
    reset_mid_cycle("async_reset");

    cycle("load_101101", 3'd5, 1'b0, 6'b101101, 1'b0, '0);
    cycle("shr_in1",     3'd1, 1'b1, '0,        1'b0, '0);
    chk("shr_const", q, 6'b110110);

    cycle("load_100100", 3'd5, 1'b0, 6'b100100, 1'b0, '0);
    cycle("asr_1",       3'd6, 1'b0, '0,        1'b0, '0);
    chk("asr1_const", q, 6'b110010);
    cycle("asr_2",       3'd6, 1'b1, '0,        1'b0, '0);
    chk("asr2_const", q, 6'b111001);

    cycle("shl_in0",  3'd2, 1'b0, '0, 1'b0, '0);
    cycle("ror",      3'd3, 1'b0, '0, 1'b0, '0);
    cycle("hold",     3'd0, 1'b1, 6'b010101, 1'b0, '0);
    cycle("clear",    3'd7, 1'b1, '0, 1'b0, '0);

    cycle("load_100001", 3'd5, 1'b0, 6'b100001, 1'b0, '0);
    busy_cycles = 0;
    cycle("rol_accept", 3'd4, 1'b0, '0, 1'b1, CW'(6));
    busy_cycles += int'(busy);
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) cycle("rol_step_start", 3'd5, 1'b1, 6'b000000, 1'b1, CW'(2));
      else        cycle("rol_step",       3'd2, 1'b0, '0,        1'b0, '0);
      busy_cycles += int'(busy);
    end
    chk("rol_busy_cycles", W'(busy_cycles), W'(6));
    chk("rol_wrap_const",  q, 6'b100001);
    cycle("rol_after_done", 3'd0, 1'b0, '0, 1'b0, '0);

    cycle("zero_count",   3'd1, 1'b1, '0, 1'b1, '0);
    cycle("load_on_done", 3'd5, 1'b0, 6'b000011, 1'b1, CW'(3));
    cycle("ror8_accept",  3'd3, 1'b0, '0, 1'b1, CW'(8));
    for (int i = 0; i < 8; i++) cycle("ror8_step", 3'd0, 1'b0, '0, 1'b0, '0);
    chk("ror8_const", q, 6'b110000);
    cycle("shr7_b2b", 3'd1, 1'b1, '0, 1'b1, CW'(7));
    for (int i = 0; i < 7; i++) cycle("shr7_step", 3'd7, 1'b1, '0, 1'b0, '0);
    chk("shr7_sat_const", q, 6'b111111);

    cycle("load_ones2", 3'd5, 1'b0, 6'b111111, 1'b0, '0);
    cycle("shl5_accept", 3'd2, 1'b0, '0, 1'b1, CW'(5));
    for (int i = 0; i < 3; i++) cycle("shl5_step", 3'd5, 1'b0, 6'b010101, 1'b0, '0);
    chk("shl3_const", q, 6'b111000);
    reset_mid_cycle("reset_mid_burst");
    cycle("post_reset_accept", 3'd1, 1'b1, '0, 1'b1, CW'(2));
    cycle("post_reset_step",   3'd0, 1'b1, '0, 1'b0, '0);
    cycle("post_reset_step",   3'd0, 1'b1, '0, 1'b0, '0);
    chk("post_reset_const", q, 6'b110000);
    cycle("post_reset_idle",   3'd0, 1'b0, '0, 1'b0, '0);

    for (int i = 0; i < 60; i++) begin
      cycle("random", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            W'($urandom), ($urandom_range(0, 3) == 0), CW'($urandom_range(0, 8)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register that generalises the lab's fixed 6-bit serial-in/serial-out register. It provides selectable hold, logical and arithmetic shift, rotate, parallel load and clear operations, plus a burst engine that runs N shift/rotate steps from one start request with a busy/done handshake. It serves as the datapath primitive for serialiser, LFSR and barrel-style exercises in later labs.

## Interface

- WIDTH, 6, register width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH)+1 (localparam), width of the burst count.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  3  operation select: 000 hold, 001 shift right, 010 shift left, 011 rotate right, 100 rotate left, 101 parallel load, 110 arithmetic shift right, 111 clear.
- serial_in  input  1  bit shifted in on shift right (into MSB) or shift left (into LSB).
- par_in  input  WIDTH  parallel load data.
- start  input  1  burst request; sampled in IDLE only.
- count  input  CNT_W  number of burst steps; 0 is legal.
- q  output  WIDTH  register contents.
- so_right  output  1  q[0], combinational from the register.
- so_left  output  1  q[WIDTH-1], combinational from the register.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at burst completion.

## Operation

- Single-step ops, applied at a clock edge with FSM in IDLE and start=0:
  - shift right: q ← {serial_in, q[W-1:1]}
  - shift left: q ← {q[W-2:0], serial_in}
  - rotate right: q ← {q[0], q[W-1:1]}
  - rotate left: q ← {q[W-2:0], q[W-1]}
  - arithmetic shift right: q ← {q[W-1], q[W-1:1]}
  - load: q ← par_in
  - clear: q ← 0
  - hold: q unchanged
- Burst-capable ops: 001, 010, 011, 100, 110. If start=1 with any other mode, start is ignored and mode executes as a single-step op. No busy or done is produced.
- FSM states:
  - IDLE → BUSY: start=1, burst-capable mode, count≠0. The accept edge latches op and rem←count. q is not changed on the accept edge.
  - IDLE → IDLE with done←1: start=1, burst-capable mode, count=0. q is unchanged.
  - BUSY: each edge applies the latched op (serial_in sampled fresh each edge) and decrements rem. On the edge where rem=1: apply op, go to IDLE, done←1.
- While in BUSY, mode, start, count and par_in are ignored. Start during BUSY is dropped, not queued.
- done is registered, high for exactly one cycle, then returns to 0 unless a new count=0 burst is accepted.
- count > WIDTH is legal. Shifts saturate to all-fill naturally. Rotates wrap modulo WIDTH.
- Reset (reset=0) takes effect asynchronously, at any time including mid-burst: q=0, busy=0, done=0, rem=0, FSM=IDLE. Consequently so_right=0 and so_left=0.

## Timing

- Single-step op latency: q updates on the edge that samples mode.
- Burst of n≥1 steps: start accepted at edge E0. Steps occur at edges E1..En. busy is high from after E0 until En. done is high for the cycle following En.
- Burst with n=0: done is high for the cycle after E0, and busy never asserts.
- The earliest next start is accepted at the edge where done is high. Back-to-back bursts therefore have no idle gap beyond the done cycle.
- Reset release is synchronised by the first clock edge. The first op can be sampled at the first rising edge with reset=1.

## Test plan

- Asynchronous reset: after loading 6'b111111, drive reset low mid-cycle → q=000000, so_left=0, busy=0 without waiting for a clock edge.
- Load then shift: load 101101, then mode=001 with serial_in=1 → q=110110, so_right=0, so_left=1.
- Arithmetic shift: load 100100, apply mode=110 once → q=110010. Apply it again → q=111001.
- Full-width burst rotate: load 100001, start with mode=100 and count=6 → busy high for exactly 6 cycles and q returns to 100001. Pulse start mid-burst; the extra start is ignored. done is high for one cycle.
- Zero-count burst: start with count=0 and mode=001 → done=1 the next cycle, busy stays 0, q unchanged. start with mode=101 → single load, and no done pulse.
- Reset mid-burst: from 111111, start with mode=010, count=5, serial_in=0. After 3 steps q=111000; assert reset → q=000000, busy=0, done=0. A new start after release is accepted normally.
